codec_cfg_sequencer: RTL
========================

// Module: codec_cfg_sequencer
// PURPOSE
//  Power-up configuration sequencer for the WM8731 codec. Walks a fixed table of
//  register writes and issues each one as a 24-bit packet to the i2c master
//  through its packet/write/idle handshake. Sits between reset/top-level control
//  and the controlador i2c port (i2c_packet, wr_i2c, i2c_idle).
//  Reports progress, completion and handshake timeout.
// PARAMETERS
//  POWERUP_DLY   1000  clk cycles to wait after reset or start before the first write
//  GAP_CYCLES    16    clk cycles between end of one write and the next wr_i2c
//  BUSY_TIMEOUT  64    max cycles from wr_i2c until i2c_idle must drop
//  AUTO_START    1     1: run automatically after reset; 0: wait for start
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  reset       in   1   asynchronous, active-high reset
//  start       in   1   one-cycle pulse; (re)runs the table; honoured only in IDLE or DONE
//  i2c_idle    in   1   i2c master ready (1) / transfer in progress (0)
//  i2c_packet  out  24  {8'h34, reg_addr[6:0], reg_data[8:0]}
//  wr_i2c      out  1   one-cycle write strobe to the i2c master
//  busy        out  1   1 while the sequence is running
//  done        out  1   1 after all entries written; held until next start or reset
//  error       out  1   1 on timeout; held until next start or reset
//  step        out  4   index of the table entry being or last written
// BEHAVIOUR
//  Reset: i2c_packet=0, wr_i2c=0, busy=0, done=0, error=0, step=0.
//   FSM in WAIT_START if AUTO_START=1, otherwise in IDLE.
//  Table (step: reg<-data): 0:R15<-000 (reset), 1:R6<-000, 2:R0<-017, 3:R1<-017,
//   4:R2<-079, 5:R3<-079, 6:R4<-012, 7:R5<-000, 8:R7<-002 (I2S, 16 bit),
//   9:R8<-000 (48 kHz, normal), 10:R9<-001 (active). Last index = 10.
//  States:
//   IDLE: busy=0. On start -> WAIT_START; clears done and error, step=0.
//   WAIT_START: busy=1. Counts POWERUP_DLY cycles -> ISSUE.
//   ISSUE: waits for i2c_idle=1. Then drives i2c_packet from table[step] and
//    pulses wr_i2c for exactly 1 cycle -> WAIT_BUSY.
//   WAIT_BUSY: i2c_idle=0 -> WAIT_IDLE.
//    BUSY_TIMEOUT cycles elapse with i2c_idle still 1 -> error=1, busy=0 -> IDLE.
//   WAIT_IDLE: on i2c_idle=1: step==10 -> DONE; otherwise step+1 -> GAP.
//    No timeout; the i2c master guarantees completion.
//   GAP: counts GAP_CYCLES -> ISSUE.
//   DONE: done=1, busy=0. On start -> WAIT_START as in IDLE.
//  i2c_packet is registered and held stable from wr_i2c until the next ISSUE.
//  wr_i2c is never asserted while i2c_idle=0.
//  start is ignored while busy=1.
//  Counters are sized by $clog2 of their parameter and saturate; they never wrap.
//  Asynchronous reset mid-write: outputs go to reset values immediately.
//   A packet already latched by the i2c master completes on its own; the new run
//   starts with R15 reset, so the codec always reaches a defined state.
// CONFIGURATION
//  CODEC_VOL_EN defined: adds ports vol_req (in, 1) and vol_level (in, 7).
//   In DONE, vol_req=1 issues one write R2<-{1'b1 LRHPBOTH, 1'b1 LZCEN, vol_level}.
//   It uses the same ISSUE/WAIT_BUSY/WAIT_IDLE handshake, then returns to DONE.
//   busy=1 and done=0 during the write. vol_req outside DONE is ignored.
//   step reads 4'hF during a volume write.
//  CODEC_VOL_EN undefined: the ports are absent and the FSM has no volume path.
// TESTING
//  1 Reset, AUTO_START=1, i2c model with 20-cycle busy: 11 wr_i2c pulses;
//    first pulse at cycle >= POWERUP_DLY; packets 24'h341E00 ... 24'h341201; done=1.
//  2 i2c_idle held 0 at the point of ISSUE: no wr_i2c until idle=1, then exactly 1 pulse.
//  3 i2c_idle never drops after wr_i2c: error=1 at BUSY_TIMEOUT; step=0; busy=0.
//  4 start pulse while busy: ignored. start in DONE: sequence reruns from step 0.
//  5 reset asserted in WAIT_IDLE at step 5: outputs zero immediately;
//    after release the run restarts at step 0.
//  6 CODEC_VOL_EN, vol_req with vol_level=7'h60 in DONE:
//    one packet 24'h3405E0; done returns to 1.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// codec_cfg_sequencer
//
// Power-up configuration sequencer for the WM8731 audio codec. After reset (or
// a start pulse) it waits for the codec supply to settle. It then walks a fixed
// table of eleven register writes. Each write goes to the i2c master as a
// 24-bit packet {8'h34, reg_addr[6:0], reg_data[8:0]}, using the master's
// packet / write-strobe / idle handshake.
//
// Parameters
//   POWERUP_DLY   cycles to wait after reset/start before the first write
//   GAP_CYCLES    cycles between the end of one write and the next strobe
//   BUSY_TIMEOUT  max cycles from wr_i2c until i2c_idle must drop
//   AUTO_START    1: run automatically after reset, 0: wait for start
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   one-cycle pulse, (re)runs the table from IDLE or DONE
//   i2c_idle    in   i2c master ready (1) / transfer in progress (0)
//   vol_req     in   (CODEC_VOL_EN only) request a headphone volume write
//   vol_level   in   (CODEC_VOL_EN only) 7-bit headphone volume
//   i2c_packet  out  24-bit packet, held from wr_i2c until the next issue
//   wr_i2c      out  one-cycle write strobe to the i2c master
//   busy        out  sequence running
//   done        out  all entries written, held until start/reset
//   error       out  handshake timeout, held until start/reset
//   step        out  table index being or last written (4'hF: volume write)
//
// Optional feature: define CODEC_VOL_EN to add the vol_req/vol_level ports.
// With the macro, DONE accepts single volume writes to R2.
// -----------------------------------------------------------------------------
module codec_cfg_sequencer #(
   parameter int POWERUP_DLY  = 1000,
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 64,
   parameter bit AUTO_START   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        i2c_idle,
`ifdef CODEC_VOL_EN
   input  logic        vol_req,
   input  logic [6:0]  vol_level,
`endif
   output logic [23:0] i2c_packet,
   output logic        wr_i2c,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [3:0]  step
);

   // One shared counter serves WAIT_START, WAIT_BUSY and GAP because those
   // states are mutually exclusive. It is sized for the largest of the three.
   localparam int CNT_MAX = (POWERUP_DLY > GAP_CYCLES)
                          ? ((POWERUP_DLY > BUSY_TIMEOUT) ? POWERUP_DLY : BUSY_TIMEOUT)
                          : ((GAP_CYCLES  > BUSY_TIMEOUT) ? GAP_CYCLES  : BUSY_TIMEOUT);
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PD_LAST  = CW'(POWERUP_DLY - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] BT_LAST  = CW'(BUSY_TIMEOUT - 1);
   localparam logic [3:0]    LAST_STEP = 4'd10;
   localparam logic [7:0]    DEV_ADDR  = 8'h34;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_IDLE,
      S_GAP,
      S_DONE
   } state_t;

   localparam state_t RESET_STATE = AUTO_START ? S_WAIT_START : S_IDLE;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]    step_q, step_d;
   logic [23:0]   packet_q, packet_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
`ifdef CODEC_VOL_EN
   logic          vol_q, vol_d;
`endif

   // Configuration table: {reg_addr[6:0], reg_data[8:0]}.
   function automatic logic [15:0] table_word(input logic [3:0] idx);
      case (idx)
         4'd0:    table_word = {7'd15, 9'h000};   // reset
         4'd1:    table_word = {7'd6,  9'h000};   // power down control
         4'd2:    table_word = {7'd0,  9'h017};   // left line in
         4'd3:    table_word = {7'd1,  9'h017};   // right line in
         4'd4:    table_word = {7'd2,  9'h079};   // left headphone
         4'd5:    table_word = {7'd3,  9'h079};   // right headphone
         4'd6:    table_word = {7'd4,  9'h012};   // analogue path
         4'd7:    table_word = {7'd5,  9'h000};   // digital path
         4'd8:    table_word = {7'd7,  9'h002};   // I2S, 16 bit
         4'd9:    table_word = {7'd8,  9'h000};   // 48 kHz, normal
         default: table_word = {7'd9,  9'h001};   // active
      endcase
   endfunction

   // Saturating increment: the counter never wraps, even if a state were held
   // far longer than its parameter.
   assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RESET_STATE;
         cnt_q    <= '0;
         step_q   <= '0;
         packet_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
`ifdef CODEC_VOL_EN
         vol_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         packet_q <= packet_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
`ifdef CODEC_VOL_EN
         vol_q    <= vol_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      step_d   = step_q;
      packet_d = packet_q;
      done_d   = done_q;
      error_d  = error_q;
      wr_i2c   = 1'b0;
`ifdef CODEC_VOL_EN
      vol_d    = vol_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT_START;
               cnt_d   = '0;
               step_d  = '0;
               done_d  = 1'b0;
               error_d = 1'b0;
            end
         end

         S_DONE: begin
            if (start) begin
               state_d = S_WAIT_START;
               cnt_d   = '0;
               step_d  = '0;
               done_d  = 1'b0;
               error_d = 1'b0;
            end
`ifdef CODEC_VOL_EN
            else if (vol_req) begin
               // R2 with LRHPBOTH and LZCEN set, so both channels follow.
               state_d  = S_ISSUE;
               packet_d = {DEV_ADDR, 7'd2, 1'b1, 1'b1, vol_level};
               vol_d    = 1'b1;
               done_d   = 1'b0;
            end
`endif
         end

         S_WAIT_START: begin
            if (cnt_q == PD_LAST) begin
               state_d  = S_ISSUE;
               packet_d = {DEV_ADDR, table_word(step_q)};
            end else begin
               cnt_d = cnt_inc;
            end
         end

         // The strobe is gated by i2c_idle combinationally, so it can never
         // appear while the master reports a transfer in progress.
         S_ISSUE: begin
            if (i2c_idle) begin
               wr_i2c  = 1'b1;
               state_d = S_WAIT_BUSY;
               cnt_d   = '0;
            end
         end

         S_WAIT_BUSY: begin
            if (!i2c_idle) begin
               state_d = S_WAIT_IDLE;
            end else if (cnt_q == BT_LAST) begin
               state_d = S_IDLE;
               error_d = 1'b1;
`ifdef CODEC_VOL_EN
               vol_d   = 1'b0;
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end

         S_WAIT_IDLE: begin
            if (i2c_idle) begin
`ifdef CODEC_VOL_EN
               if (vol_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  vol_d   = 1'b0;
               end else
`endif
               if (step_q == LAST_STEP) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_GAP;
                  step_d  = step_q + 4'd1;
                  cnt_d   = '0;
               end
            end
         end

         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d  = S_ISSUE;
               packet_d = {DEV_ADDR, table_word(step_q)};
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // busy is registered from the next state. It therefore reads 0 during
   // reset, even though the FSM may already sit in WAIT_START.
   assign busy_d = (state_d != S_IDLE) && (state_d != S_DONE);

   assign i2c_packet = packet_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
`ifdef CODEC_VOL_EN
   assign step       = vol_q ? 4'hF : step_q;
`else
   assign step       = step_q;
`endif

endmodule
